spi_slave_gen: RTL and testbench

Parametrised SPI slave front-end for the single-port-RAM wrapper. It deserialises MOSI frames of WORD_W+2 bits into a command-tagged parallel word for the RAM, and serialises RAM read data back on MISO. Beyond the fixed 8-bit generation, it adds:
- a configurable word width;
- command-tag checking;
- frame-abort and read-timeout error reporting;
- a visible read-address status flag.

---
 rtl/spi_slave_gen_if.sv | 24 ++
 rtl/spi_slave_gen.sv | 174 +++++++++++++++++
 tb/tb_spi_slave_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_gen_if.sv
// SPI slave bus bundle: serial pins, RAM-side read data and the deserialised frame outputs.
interface spi_slave_gen_if #(
  parameter int unsigned WORD_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic [WORD_W+1:0] rx_data;
  logic              rx_valid;
  logic              MISO;
  logic              frame_err;
  logic              addr_held;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  rx_data, rx_valid, MISO, frame_err, addr_held
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output rx_data, rx_valid, MISO, frame_err, addr_held
  );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave front-end: deserialises tagged MOSI frames for the RAM and serialises read data on MISO,
// with tag checking, abort/timeout error pulses and a held-read-address flag.
module spi_slave_gen #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_gen_if.slave bus
);

  localparam int unsigned RX_W  = WORD_W + 2;
  localparam int unsigned CNT_W = $clog2(WORD_W + 3);
  localparam int unsigned TO_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam bit          TO_EN = (TX_TIMEOUT != 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_N  = CNT_W'(WORD_W + 2);
  localparam logic [CNT_W-1:0] SHIFT_N  = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_SHIFT, HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              frame_err_q, frame_err_d;
  logic              addr_held_q, addr_held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  logic [1:0] cmd_c;
  logic       last_c;
  logic       tag_ok_c;

  // Tag bits as they will stand once the final MOSI bit is shifted in.
  assign cmd_c  = rx_data_q[WORD_W:WORD_W-1];
  assign last_c = (cnt_q == CNT_W'(1));

  always_comb begin
    tag_ok_c = 1'b0;
    case (state_q)
      WRITE:     tag_ok_c = ~cmd_c[1];
      READ_ADD:  tag_ok_c = (cmd_c == 2'b10);
      READ_DATA: tag_ok_c = (cmd_c == 2'b11);
      default:   tag_ok_c = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      addr_held_q <= 1'b0;
      cnt_q       <= '0;
      wait_q      <= '0;
      sr_q        <= '0;
    end else begin
      state_q     <= state_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      addr_held_q <= addr_held_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      sr_q        <= sr_d;
    end
  end

  // Next-state logic; SS_n high aborts every in-frame state back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.SS_n) state_d = CMD;
      CMD: begin
        if (bus.SS_n)         state_d = IDLE;
        else if (!bus.MOSI)   state_d = WRITE;
        else if (addr_held_q) state_d = READ_DATA;
        else                  state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) state_d = IDLE;
        else if (last_c) state_d = (tag_ok_c && state_q == READ_DATA) ? READ_WAIT : HOLD;
      end
      READ_WAIT: begin
        if (bus.SS_n)                           state_d = IDLE;
        else if (bus.tx_valid)                  state_d = READ_SHIFT;
        else if (TO_EN && wait_q == TO_LAST)    state_d = HOLD;
      end
      READ_SHIFT: begin
        if (bus.SS_n)                state_d = IDLE;
        else if (cnt_q == '0)        state_d = HOLD;
      end
      HOLD: if (bus.SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    addr_held_d = addr_held_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    sr_d        = sr_q;
    case (state_q)
      CMD: if (!bus.SS_n) cnt_d = FRAME_N;
      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else begin
          rx_data_d = {rx_data_q[WORD_W:0], bus.MOSI};
          cnt_d     = cnt_q - CNT_W'(1);
          if (last_c) begin
            if (tag_ok_c) begin
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) addr_held_d = 1'b1;
              wait_d = '0;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      READ_WAIT: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (bus.tx_valid) begin
          miso_d = bus.tx_data[WORD_W-1];
          sr_d   = {bus.tx_data[WORD_W-2:0], 1'b0};
          cnt_d  = SHIFT_N;
        end else if (TO_EN && wait_q == TO_LAST) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (TO_EN) begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      READ_SHIFT: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (cnt_q != '0) begin
          miso_d = sr_q[WORD_W-1];
          sr_d   = {sr_q[WORD_W-2:0], 1'b0};
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          miso_d      = 1'b0;
          addr_held_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.MISO      = miso_q;
  assign bus.frame_err = frame_err_q;
  assign bus.addr_held = addr_held_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboarded bench for spi_slave_gen: directed frames push expected events, a negedge monitor checks them.
module tb_spi_slave_gen;
  localparam int unsigned W = 8;

  typedef struct {
    bit         is_err;
    logic [9:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ev_t        ev_q[$];
  logic [7:0] tx_exp_q[$];

  spi_slave_gen_if #(.WORD_W(W)) bus();

  spi_slave_gen #(.WORD_W(W), .TX_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rx(input logic [9:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    ev_q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    ev_q.push_back(e);
  endtask

  // Direction bit, then n of the 10 frame bits MSB first; optionally SS_n raised for one edge afterwards.
  task automatic frame(input logic d, input logic [9:0] p, input int n, input bit keep_low);
    bus.SS_n = 1'b0;
    tick();
    bus.MOSI = d;
    tick();
    for (int i = 0; i < n; i++) begin
      bus.MOSI = p[9-i];
      tick();
    end
    bus.MOSI = 1'b0;
    if (!keep_low) begin
      bus.SS_n = 1'b1;
      tick();
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    tick();
  endtask

  // Monitor: consumes rx/err events and collects MISO words after an accepted tx_valid.
  int         phase = 0;
  logic [7:0] got;
  logic [7:0] cur_word;
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
    end else begin
      if (phase >= 1 && phase <= int'(W)) begin
        got = {got[6:0], bus.MISO};
        phase++;
        if (phase == int'(W) + 1) check("miso_word", 32'(got), 32'(cur_word));
      end else if (phase == int'(W) + 1) begin
        check("miso_after_word", 32'(bus.MISO), 32'(0));
        phase = 0;
      end
      if (phase == 0 && bus.tx_valid && tx_exp_q.size() > 0) begin
        cur_word = tx_exp_q.pop_front();
        phase = 1;
      end
      if (bus.rx_valid || bus.frame_err) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", 32'({bus.frame_err, bus.rx_valid}), 32'(0));
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          if (e.is_err)
            check("err_event", 32'({bus.frame_err, bus.rx_valid}), 32'(2'b10));
          else
            check("rx_event", 32'({bus.frame_err, bus.rx_valid, bus.rx_data}), 32'({2'b01, e.data}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    tick();
    tick();
    check("reset_rx_data", 32'(bus.rx_data), 32'(0));
    check("reset_flags", 32'({bus.rx_valid, bus.MISO, bus.frame_err, bus.addr_held}), 32'(0));
    rst = 1'b0;
    tick();

    // Plain write-address frame.
    exp_rx(10'h0A5);
    frame(1'b0, 10'h0A5, 10, 1'b0);
    check("write_addr_held", 32'(bus.addr_held), 32'(0));

    // Read-address frame sets addr_held.
    exp_rx(10'h233);
    frame(1'b1, 10'h233, 10, 1'b0);
    check("read_addr_held", 32'(bus.addr_held), 32'(1));

    // Write frame carrying a read tag: error, flag untouched.
    exp_err();
    frame(1'b0, 10'h201, 10, 1'b0);
    check("bad_tag_held", 32'(bus.addr_held), 32'(1));

    // Read-data frame, tx_valid on the third waiting edge.
    exp_rx(10'h300);
    frame(1'b1, 10'h300, 10, 1'b1);
    tick();
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hC3;
    tx_exp_q.push_back(8'hC3);
    tick();
    bus.tx_valid = 1'b0;
    check("read_data_held_mid", 32'(bus.addr_held), 32'(1));
    for (int i = 0; i < 8; i++) tick();
    check("read_data_held_done", 32'(bus.addr_held), 32'(0));
    end_frame();

    // Abort after four payload bits, then a normal frame.
    exp_err();
    frame(1'b0, 10'h13C, 4, 1'b0);
    exp_rx(10'h13C);
    frame(1'b0, 10'h13C, 10, 1'b0);

    // Timeout: no tx_valid within four waiting edges.
    exp_rx(10'h20F);
    frame(1'b1, 10'h20F, 10, 1'b0);
    exp_rx(10'h3A0);
    frame(1'b1, 10'h3A0, 10, 1'b1);
    exp_err();
    for (int i = 0; i < 4; i++) tick();
    check("timeout_err", 32'(bus.frame_err), 32'(1));
    check("timeout_miso", 32'(bus.MISO), 32'(0));
    check("timeout_held", 32'(bus.addr_held), 32'(1));
    end_frame();

    // tx_valid on the fourth waiting edge beats the timeout.
    exp_rx(10'h355);
    frame(1'b1, 10'h355, 10, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h5A;
    tx_exp_q.push_back(8'h5A);
    tick();
    bus.tx_valid = 1'b0;
    check("late_valid_no_err", 32'(bus.frame_err), 32'(0));
    for (int i = 0; i < 8; i++) tick();
    check("late_valid_held", 32'(bus.addr_held), 32'(0));
    end_frame();

    // Reset in the middle of a shift-out.
    exp_rx(10'h2AA);
    frame(1'b1, 10'h2AA, 10, 1'b0);
    exp_rx(10'h3FF);
    frame(1'b1, 10'h3FF, 10, 1'b1);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hFF;
    tick();
    bus.tx_valid = 1'b0;
    tick();
    tick();
    check("inflight_miso", 32'(bus.MISO), 32'(1));
    check("inflight_held", 32'(bus.addr_held), 32'(1));
    rst = 1'b1;
    bus.SS_n = 1'b1;
    #1;
    check("async_rst_flags", 32'({bus.rx_valid, bus.MISO, bus.frame_err, bus.addr_held}), 32'(0));
    check("async_rst_rx_data", 32'(bus.rx_data), 32'(0));
    tick();
    rst = 1'b0;
    tick();

    // Fresh frame after reset proves the FSM is back in IDLE.
    exp_rx(10'h155);
    frame(1'b0, 10'h155, 10, 1'b0);
    check("post_rst_rx_data", 32'(bus.rx_data), 32'(10'h155));

    tick();
    tick();
    check("events_drained", 32'(ev_q.size()), 32'(0));
    check("tx_words_drained", 32'(tx_exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
